// File: rtl/bnmm_pkg.sv
// Shared types and constants for the synaptic accumulator slice.
// Holds default sizing, the datapath typedefs, accumulator range limits
// and the accumulator FSM state encoding.
package bnmm_pkg;

  localparam int unsigned DEF_NUM_NEURONS = 256;
  localparam int unsigned DEF_IDX_W       = 8;
  localparam int unsigned DEF_W_W         = 16;
  localparam int unsigned DEF_ACC_W       = 24;

  typedef logic        [DEF_IDX_W-1:0] post_idx_t;
  typedef logic signed [DEF_W_W-1:0]   weight_t;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CLEAR
  } acc_state_e;

endpackage

// File: rtl/synaptic_acc_mem.sv
// Membrane-potential register file: NUM_NEURONS x ACC_W.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset (zeroes every entry)
//   we_i/waddr_i/wdata_i  single write port
//   raddr_i -> rdata_o    combinational read (pipeline S1 operand fetch)
//   rd_idx_i -> rd_data_o registered read, 1-cycle latency, returns the value
//                         committed before the read edge
// Addresses >= NUM_NEURONS read as zero.
module synaptic_acc_mem
  import bnmm_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned IDX_W       = DEF_IDX_W,
  parameter int unsigned ACC_W       = DEF_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [ACC_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [ACC_W-1:0] rdata_o,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ACC_W-1:0] rd_data_o
);

  logic [ACC_W-1:0] mem [NUM_NEURONS];

  assign rdata_o = (32'(raddr_i) < NUM_NEURONS) ? mem[raddr_i] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem       <= '{default: '0};
      rd_data_o <= '0;
    end else begin
      if (we_i) mem[waddr_i] <= wdata_i;
      rd_data_o <= (32'(rd_idx_i) < NUM_NEURONS) ? mem[rd_idx_i] : '0;
    end
  end

endmodule

// File: rtl/synaptic_accumulator.sv
// Synaptic accumulator: adds a (post index, weight) stream into per-neuron
// membrane potentials through a 2-stage read-modify-write pipeline.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o        weight-stream handshake
//   in_post_idx_i, in_weight_i   target neuron, signed weight
//   in_last_i                    final entry of a presynaptic row
//   clear_i                      pulse: zero all entries (deferred until drained)
//   busy_o                       pipeline occupied or clear pending/in progress
//   done_o                       1-cycle pulse when the last entry of a row commits
//   rd_idx_i -> rd_data_o        registered read port, 1-cycle latency
//   ovf_o, err_o                 sticky overflow / out-of-range index flags
// Build option: ACC_SATURATE_EN clamps sums to the signed range instead of wrapping.
module synaptic_accumulator
  import bnmm_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned IDX_W       = DEF_IDX_W,
  parameter int unsigned W_W         = DEF_W_W,
  parameter int unsigned ACC_W       = DEF_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IDX_W-1:0] in_post_idx_i,
  input  logic [W_W-1:0]   in_weight_i,
  input  logic             in_last_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  acc_state_e       state, state_nx;
  logic             clr_pend;
  logic [IDX_W-1:0] clr_cnt;
  logic             hs, in_oob, clr_enter;

  logic             s1_valid, s1_last, s1_oob;
  logic [IDX_W-1:0] s1_idx;
  logic [ACC_W-1:0] s1_w, s1_acc;
  logic             s2_valid;

  logic [ACC_W-1:0] sum_wrap, sum_commit;
  logic             sum_ovf;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [ACC_W-1:0] mem_wdata, mem_rdata;

  assign in_ready_o = (state != CLEAR) && !clr_pend;
  assign hs         = in_valid_i && in_ready_o;
  assign in_oob     = 32'(in_post_idx_i) >= NUM_NEURONS;
  assign busy_o     = (state != IDLE) || clr_pend || s1_valid || s2_valid;
  assign clr_enter  = (state != CLEAR) && (state_nx == CLEAR);

  // S2 arithmetic: overflow when both operands share a sign the result lacks.
  always_comb begin
    sum_wrap = s1_acc + s1_w;
    sum_ovf  = (s1_acc[ACC_W-1] == s1_w[ACC_W-1]) && (sum_wrap[ACC_W-1] != s1_acc[ACC_W-1]);
`ifdef ACC_SATURATE_EN
    sum_commit = sum_ovf ? (s1_acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum_wrap;
`else
    sum_commit = sum_wrap;
`endif
  end

  // Single write port shared by the clear sweep and the S2 commit; the FSM
  // guarantees the pipeline is empty while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_idx;
    mem_wdata = sum_commit;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (s1_valid && !s1_oob) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (hs)                       state_nx = ACCUM;
        else if (clear_i || clr_pend) state_nx = CLEAR;
      end
      ACCUM: if (!hs && !s1_valid && !s2_valid) state_nx = IDLE;
      CLEAR: if (clr_cnt == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      clr_pend <= 1'b0;
      clr_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_oob   <= 1'b0;
      s1_idx   <= '0;
      s1_w     <= '0;
      s1_acc   <= '0;
      s2_valid <= 1'b0;
      done_o   <= 1'b0;
      ovf_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nx;
      s1_valid <= hs;
      s2_valid <= s1_valid;
      done_o   <= s1_valid && s1_last;
      if (hs) begin
        s1_idx  <= in_post_idx_i;
        s1_w    <= {{(ACC_W-W_W){in_weight_i[W_W-1]}}, in_weight_i};
        s1_last <= in_last_i;
        s1_oob  <= in_oob;
        // The array still holds the pre-commit value on this edge, so take
        // the sum being written by S2 when it targets the same neuron.
        s1_acc  <= (s1_valid && (s1_idx == in_post_idx_i)) ? sum_commit : mem_rdata;
      end
      if (clr_enter) begin
        clr_pend <= 1'b0;
        clr_cnt  <= '0;
        ovf_o    <= 1'b0;
        err_o    <= 1'b0;
      end else begin
        if (clear_i && (state != CLEAR)) clr_pend <= 1'b1;
        if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        if (s1_valid && s1_oob) err_o <= 1'b1;
        if (s1_valid && !s1_oob && sum_ovf) ovf_o <= 1'b1;
      end
    end
  end

  synaptic_acc_mem #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .ACC_W       (ACC_W)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_i   (in_post_idx_i),
    .rdata_o   (mem_rdata),
    .rd_idx_i  (rd_idx_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Self-checking bench for synaptic_accumulator (NUM_NEURONS = 200).
// A sequential reference model (one committed entry per edge, applied in
// order) drives a per-cycle compare process; directed tests add literal
// expectations. Honours ACC_SATURATE_EN for the expected overflow result.
module tb_synaptic_accumulator;
  import bnmm_pkg::*;

  localparam int N = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, clear;
  logic [7:0]  in_post_idx, rd_idx;
  logic [15:0] in_weight;
  logic        in_ready, busy, done, ovf, err;
  logic [23:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  synaptic_accumulator #(
    .NUM_NEURONS (N),
    .IDX_W       (8),
    .W_W         (16),
    .ACC_W       (24)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_post_idx_i (in_post_idx),
    .in_weight_i   (in_weight),
    .in_last_i     (in_last),
    .clear_i       (clear),
    .busy_o        (busy),
    .done_o        (done),
    .rd_idx_i      (rd_idx),
    .rd_data_o     (rd_data),
    .ovf_o         (ovf),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  longint      m_acc [N];
  logic        m_slot_v, m_slot_last;
  int          m_slot_idx;
  longint      m_slot_w;
  logic        exp_done, exp_ovf, exp_err, exp_rd_known, clr_win;
  logic [23:0] exp_rd;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_slot_v = 1'b0; m_slot_last = 1'b0; m_slot_idx = 0; m_slot_w = 0;
    exp_done = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
    exp_rd = '0; exp_rd_known = 1'b1; clr_win = 1'b0;
  endtask

  task automatic model_commit();
    longint s;
    if (m_slot_idx >= N) begin
      exp_err = 1'b1;
    end else begin
      s = m_acc[m_slot_idx] + m_slot_w;
      if (s > longint'(ACC_MAX) || s < longint'(ACC_MIN)) begin
        exp_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        s = (s > 0) ? longint'(ACC_MAX) : longint'(ACC_MIN);
`else
        s = (s > 0) ? s - 64'sd16777216 : s + 64'sd16777216;
`endif
      end
      m_acc[m_slot_idx] = s;
    end
  endtask

  // Predicts the effect of the coming rising edge from the inputs now stable.
  task automatic model_advance();
    logic hs;
    hs = in_valid && !clr_win;
    if (int'(rd_idx) < N) exp_rd = 24'(m_acc[int'(rd_idx)]);
    else exp_rd = '0;
    exp_rd_known = !clr_win;
    exp_done = 1'b0;
    if (m_slot_v) begin
      model_commit();
      exp_done = m_slot_last;
    end
    m_slot_v = hs;
    if (hs) begin
      m_slot_idx  = int'(in_post_idx);
      m_slot_w    = longint'($signed(in_weight));
      m_slot_last = in_last;
    end
    if (clear) clr_win = 1'b1;
  endtask

  // Called once the clear sweep has finished.
  task automatic model_end_clear();
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    exp_ovf = 1'b0; exp_err = 1'b0; clr_win = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("cmp_done", done, exp_done);
    if (!clr_win) begin
      chk("cmp_ready", in_ready, 1'b1);
      chk("cmp_ovf", ovf, exp_ovf);
      chk("cmp_err", err, exp_err);
    end
    if (exp_rd_known === 1'b1) chk("cmp_rd", rd_data, exp_rd);
    model_advance();
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_lit(input string name, input int idx, input logic [23:0] exp);
    rd_idx = 8'(idx);
    tick();
    chk(name, rd_data, exp);
  endtask

  initial begin
    logic [23:0] t3_exp;
    int          cyc, busy_low, nz;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
    in_post_idx = '0; in_weight = '0; rd_idx = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd", rd_data, 24'h0);

    // Single entry: done exactly 2 cycles after the handshake
    in_valid = 1'b1; in_post_idx = 8'd5; in_weight = 16'd100; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_done_c1", done, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_done_c2", done, 1'b1);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    rd_lit("t1_acc5", 5, 24'd100);
    repeat (3) tick();
    chk("t1_idle_busy", busy, 1'b0);

    // Back-to-back same index exercises forwarding
    in_valid = 1'b1; in_post_idx = 8'd3; in_last = 1'b0;
    in_weight = 16'd10; tick();
    in_weight = 16'd20; tick();
    in_weight = 16'hFFFB; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) tick();
    rd_lit("t2_acc3", 3, 24'd25);

    // Overflow: 256 x 0x7FFF = 0x7FFF00, then one more 0x7FFF
    in_valid = 1'b1; in_post_idx = 8'd7; in_weight = 16'h7FFF; in_last = 1'b0;
    repeat (256) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rd_lit("t3_preload", 7, 24'h7FFF00);
    chk("t3_ovf_pre", ovf, 1'b0);
    in_valid = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) tick();
`ifdef ACC_SATURATE_EN
    t3_exp = 24'h7FFFFF;
`else
    t3_exp = 24'h807EFF;
`endif
    rd_lit("t3_acc7", 7, t3_exp);
    chk("t3_ovf", ovf, 1'b1);

    // Out-of-range index: accepted, no write, err set, done still pulses
    in_valid = 1'b1; in_post_idx = 8'd210; in_weight = 16'd1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_err_pre", err, 1'b0);
    tick();
    chk("t4_done", done, 1'b1);
    chk("t4_err", err, 1'b1);
    rd_lit("t4_acc3", 3, 24'd25);

    // Clear requested mid-stream
    in_valid = 1'b1; in_last = 1'b0;
    in_post_idx = 8'd10; in_weight = 16'd1; tick();
    in_post_idx = 8'd11; in_weight = 16'd2; tick();
    in_post_idx = 8'd12; in_weight = 16'd3; clear = 1'b1; tick();
    clear = 1'b0;
    chk("t5_ready_drop", in_ready, 1'b0);
    chk("t5_busy", busy, 1'b1);
    in_post_idx = 8'd13; in_weight = 16'd4;
    tick();
    in_valid = 1'b0;
    busy_low = 0;
    repeat (20) begin
      tick();
      if (busy !== 1'b1) busy_low++;
    end
    clear = 1'b1; tick(); clear = 1'b0;
    cyc = 22;
    while (in_ready !== 1'b1 && cyc < N + 40) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
    chk("t5_clear_done", in_ready, 1'b1);
    chk("t5_len_min", 32'(cyc >= N), 1);
    chk("t5_len_max", 32'(cyc <= N + 10), 1);
    chk("t5_busy_held", busy_low, 0);
    model_end_clear();
    chk("t5_ovf", ovf, 1'b0);
    chk("t5_err", err, 1'b0);
    nz = 0;
    for (int i = 0; i < N; i++) begin
      rd_idx = 8'(i);
      tick();
      if (rd_data !== 24'h0) nz++;
    end
    chk("t5_all_zero", nz, 0);

    // Reset with both pipeline stages occupied
    rd_idx = 8'd20; in_valid = 1'b1;
    in_post_idx = 8'd20;  in_weight = 16'd50; in_last = 1'b0; tick();
    in_post_idx = 8'd230; in_weight = 16'd1;  in_last = 1'b1; tick();
    in_post_idx = 8'd20;  in_weight = 16'd50; in_last = 1'b0; tick();
    chk("t6_pre_done", done, 1'b1);
    chk("t6_pre_err", err, 1'b1);
    chk("t6_pre_rd", rd_data, 24'd50);
    #1 in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_err", err, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rd", rd_data, 24'h0);
    chk("t6_rst_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_post_idx = 8'd20; in_weight = 16'd7; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) tick();
    rd_lit("t6_acc20", 20, 24'd7);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
